// File: rtl/c64_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c64_debug_pkg
// Description : Shared types and constants for the C64 debug-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package c64_debug_pkg;

  // Arbiter controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Read data returned to a requester whose access was aborted by the watchdog
  localparam logic [7:0] DEBUG_ARB_TIMEOUT_RDATA = 8'hFF;

  // Default watchdog limit in clk cycles
  localparam int DEBUG_ARB_TIMEOUT_CYCLES = 1000000;

endpackage : c64_debug_pkg
`default_nettype wire

// File: rtl/c64_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : c64_rr_pick
// Description : Combinational round-robin picker. Searches upward from
//               last_grant+1, wrapping modulo N_REQ, for the first set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module c64_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  // One extra bit so last_grant + offset never overflows before the wrap
  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  // Walk candidates in priority order; the first requesting one wins
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_grant} + CW'(i);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!any_req && req[cand[IDX_W-1:0]]) begin
        grant   = cand[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule : c64_rr_pick
`default_nettype wire

// File: rtl/c64_debug_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : c64_debug_arbiter
// Description : Round-robin arbiter sharing the C64 debug memory port between
//               N_REQ debug masters. One byte access per grant; the winner
//               gets a one-cycle ack pulse with the read byte.
//               Optional watchdog: define DEBUG_ARB_TIMEOUT_EN to abort
//               accesses not acknowledged within TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module c64_debug_arbiter
  import c64_debug_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = DEBUG_ARB_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [16*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0]  req_wdata,
  output logic [N_REQ-1:0]    req_ack,
  output logic [N_REQ-1:0]    req_err,
  output logic [7:0]          req_rdata,
  output logic                debug_request,
  output logic [15:0]         debug_addr,
  output logic [7:0]          debug_data_o,
  output logic                debug_we,
  input  logic                debug_ack,
  input  logic [7:0]          debug_data_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Reject unsupported configurations at elaboration
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("c64_debug_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             load;
  logic             complete;
  logic             abort;
  logic             timeout_hit;
  logic [N_REQ-1:0] ack_onehot;

  logic [15:0] addr_arr  [N_REQ];
  logic [7:0]  wdata_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[16*i +: 16];
    assign wdata_arr[i] = req_wdata[8*i +: 8];
  end

  c64_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .any_req    (any_req)
  );

  // last_grant doubles as the index of the access in flight
  assign ack_onehot = N_REQ'(1) << last_grant;

`ifdef DEBUG_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wd_cnt;

  // Watchdog: zero outside BUSY, so it starts from zero on every BUSY entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state != BUSY) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Error pulse accompanies the ack only on a watchdog abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_err <= '0;
    end else begin
      req_err <= abort ? ack_onehot : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign req_err     = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath strobes; downstream ack counts only in BUSY
  always_comb begin
    state_next = state;
    load       = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (debug_ack) begin
          complete   = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner onto the downstream port and return the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debug_request <= 1'b0;
      debug_we      <= 1'b0;
      debug_addr    <= '0;
      debug_data_o  <= '0;
      req_ack       <= '0;
      req_rdata     <= '0;
      last_grant    <= IDX_W'(N_REQ - 1);
    end else begin
      req_ack <= '0;
      if (load) begin
        debug_addr    <= addr_arr[pick];
        debug_data_o  <= wdata_arr[pick];
        debug_we      <= req_we[pick];
        debug_request <= 1'b1;
        last_grant    <= pick;
      end
      if (complete || abort) begin
        req_ack       <= ack_onehot;
        req_rdata     <= abort    ? DEBUG_ARB_TIMEOUT_RDATA :
                         debug_we ? 8'h00 : debug_data_i;
        debug_request <= 1'b0;
        debug_we      <= 1'b0;
      end
    end
  end

endmodule : c64_debug_arbiter
`default_nettype wire
